// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one lookahead group per stage.
// Valid/ready stream with a global stall; flags come from the last stage.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int GSAFE  = (GROUP < 1) ? 1 : GROUP;
    localparam int STAGES = WIDTH / GSAFE;

    if (GROUP < 1) begin : g_bad_group
        $error("pipelined_cla_adder: GROUP must be >= 1");
    end else if (WIDTH % GROUP != 0) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] nv;
    logic [WIDTH-1:0]  ra [STAGES];
    logic [WIDTH-1:0]  rb [STAGES];
    logic [WIDTH-1:0]  rs [STAGES];
    logic              rc [STAGES];
    logic              rm [STAGES];
    logic [WIDTH-1:0]  na [STAGES];
    logic [WIDTH-1:0]  nb [STAGES];
    logic [WIDTH-1:0]  ns [STAGES];
    logic              nc [STAGES];
    logic              nm [STAGES];

    logic             stall;
    logic [WIDTH-1:0] beff;
    logic             c0;
    logic [WIDTH-1:0] ia;
    logic [WIDTH-1:0] ib;
    logic [WIDTH-1:0] is;
    logic             ic;
    logic             iv;
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   cv;

    // Fully expanded lookahead: every carry is a sum of products of g/p/cin.
    function automatic logic [GROUP:0] lookahead(
        input logic [GROUP-1:0] gi,
        input logic [GROUP-1:0] pi,
        input logic             ci
    );
        logic [GROUP:0] c;
        logic           acc;
        logic           pp;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (pp & gi[j]);
                pp  = pp & pi[j];
            end
            c[i+1] = acc | (pp & ci);
        end
        return c;
    endfunction

    assign out_valid = vld[STAGES-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign S         = rs[STAGES-1];
    assign Cout      = rc[STAGES-1];
    assign Ovf       = rm[STAGES-1] ^ rc[STAGES-1];

    assign beff = Sub ? ~B : B;
    assign c0   = Sub ? ~Cin : Cin;

    always_comb begin
        ia = '0;
        ib = '0;
        is = '0;
        ic = 1'b0;
        iv = 1'b0;
        g  = '0;
        p  = '0;
        cv = '0;
        nv = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                ia = A;
                ib = beff;
                is = '0;
                ic = c0;
                iv = in_valid;
            end else begin
                ia = ra[(k == 0) ? 0 : k - 1];
                ib = rb[(k == 0) ? 0 : k - 1];
                is = rs[(k == 0) ? 0 : k - 1];
                ic = rc[(k == 0) ? 0 : k - 1];
                iv = vld[(k == 0) ? 0 : k - 1];
            end
            g  = ia[k*GROUP +: GROUP] & ib[k*GROUP +: GROUP];
            p  = ia[k*GROUP +: GROUP] ^ ib[k*GROUP +: GROUP];
            cv = lookahead(g, p, ic);
            is[k*GROUP +: GROUP] = p ^ cv[GROUP-1:0];
            na[k] = ia;
            nb[k] = ib;
            ns[k] = is;
            nc[k] = cv[GROUP];
            nm[k] = cv[GROUP-1];
            nv[k] = iv;
        end
    end

    // Whole pipeline freezes while the output is held by the consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ra[k] <= '0;
                rb[k] <= '0;
                rs[k] <= '0;
                rc[k] <= 1'b0;
                rm[k] <= 1'b0;
            end
        end else if (!stall) begin
            vld <= nv;
            for (int k = 0; k < STAGES; k++) begin
                ra[k] <= na[k];
                rb[k] <= nb[k];
                rs[k] <= ns[k];
                rc[k] <= nc[k];
                rm[k] <= nm[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (WIDTH=16, GROUP=4).
// A negedge monitor checks every emitted result against a queue of expectations.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Cin = 1'b0;
    logic        Sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] S;
    logic        Cout;
    logic        Ovf;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nout = 0;
    int          irlow = 0;
    bit          chk_lat = 1'b1;
    logic        prev_stall = 1'b0;
    logic [15:0] held = '0;

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(A),
        .B(B),
        .Cin(Cin),
        .Sub(Sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S(S),
        .Cout(Cout),
        .Ovf(Ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !in_ready) irlow++;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else if (prev_stall) begin
                check("hold_s", 32'(S), 32'(held));
            end else begin
                check("s", 32'(S), 32'(q[0].s));
                check("cout", 32'(Cout), 32'(q[0].c));
                check("ovf", 32'(Ovf), 32'(q[0].o));
                if (chk_lat) check("latency", 32'(cyc - q[0].cyc), 32'd4);
            end
            if (out_ready && q.size() > 0) begin
                void'(q.pop_front());
                nout++;
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        held = S;
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        int   n;
        n = 0;
        A = a;
        B = b;
        Cin = ci;
        Sub = sb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("accept", 32'(in_ready), 32'd1);
        e.s = es;
        e.c = ec;
        e.o = eo;
        e.cyc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_s", 32'(S), 32'd0);
        check("rst_cout", 32'(Cout), 32'd0);
        check("rst_ovf", 32'(Ovf), 32'd0);
        @(posedge clk);
        #1;

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        drain();

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        drain();

        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
        drain();

        chk_lat = 1'b0;
        irlow = 0;
        n0 = nout;
        fork
            begin
                send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
                send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
                send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
                send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
                send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
                send(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);
                send(16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
                send(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
            end
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 50) begin
                    w++;
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_ready_low", 32'(irlow), 32'd3);
        check("bp_count", 32'(nout - n0), 32'd8);
        chk_lat = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (i == 0)
                send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
            else if (i == 2)
                send(16'h2222, 16'h1111, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
            else if (i == 4)
                send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
            else begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        drain();

        send(16'h1111, 16'h1111, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0);
        send(16'h2222, 16'h2222, 1'b0, 1'b0, 16'h4444, 1'b0, 1'b0);
        send(16'h3333, 16'h3333, 1'b0, 1'b0, 16'h6666, 1'b0, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b1;
        A = 16'h00AA;
        B = 16'h0001;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_s", 32'(S), 32'd0);
        check("mid_rst_cout", 32'(Cout), 32'd0);
        check("mid_rst_ovf", 32'(Ovf), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        repeat (8) @(posedge clk);
        #1;
        n0 = nout;
        send(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);
        drain();
        check("post_rst_count", 32'(nout - n0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the team's 4-bit combinational CLA.
- Splits a WIDTH-bit operation into WIDTH/GROUP lookahead groups, one group per pipeline stage, with a registered inter-group carry.
- Valid/ready streaming interface with full backpressure; one operation accepted per cycle.
- Sits between operand-producing datapath logic and the ALU result bus.

Parameters:
- WIDTH, 16, operand and result width in bits.
- GROUP, 4, bits per lookahead group; also bits resolved per pipeline stage.
- Derived: STAGES = WIDTH/GROUP. WIDTH % GROUP != 0 or GROUP < 1 is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept an operand set this cycle.
- A  input  WIDTH  operand A (two's complement or unsigned).
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) / borrow-in (subtract).
- Sub  input  1  0 = A+B+Cin; 1 = A-B-Cin.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- S  output  WIDTH  sum/difference, modulo 2^WIDTH.
- Cout  output  1  raw carry out of the MSB group.
- Ovf  output  1  signed overflow.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all stage valid bits, out_valid, S, Cout and Ovf are cleared to 0. All in-flight operations are discarded. in_ready=1 from the first cycle after reset.
- Accept: an operand set is taken when in_valid && in_ready at the edge.
- Operand mapping: Beff = Sub ? ~B : B; c0 = Sub ? ~Cin : Cin. The result is always A + Beff + c0.
- Subtract flags: Cout=1 means no borrow, Cout=0 means borrow.
- Stage k (0..STAGES-1) resolves bits [k*GROUP +: GROUP]:
  - per-bit g=A&Beff, p=A^Beff;
  - group carries computed by lookahead (c[i+1] = g[i] | p[i]&c[i], flattened) from the registered carry of stage k-1 (c0 for stage 0);
  - sum bits = p ^ c.
- Pipeline registers: each stage forwards the unresolved upper operand bits, the resolved lower sum bits, its group carry-out, the carry into the MSB, and a valid bit.
- Latency: exactly STAGES cycles from accept to out_valid=1, with no stall. Throughput: 1 op/cycle.
- Flags: Cout = carry out of bit WIDTH-1. Ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Backpressure is a global stall:
  - stall = out_valid && !out_ready;
  - in_ready = !stall;
  - while stalled, every stage register holds; S/Cout/Ovf stay stable.
- Bubbles: an invalid stage entry advances when not stalled. Bubbles do not block younger ops.
- Ordering: results emerge strictly in acceptance order. No drop or duplication under any stall pattern.
- out_ready is ignored when out_valid=0. Outputs are registered with no combinational input-to-output path, except in_ready from out_valid/out_ready.
- Simultaneous accept and result handoff in the same cycle is legal and sustains full rate.
- Reset mid-stream: all ops are lost, nothing is emitted afterwards. An input presented in the reset cycle is not accepted.
- Degenerate case: GROUP=WIDTH gives a 1-stage registered CLA (latency 1).

Test Plan (WIDTH=16, GROUP=4, out_ready=1 unless stated):
- A=0xFFFF, B=0x0001, Cin=0, Sub=0 -> 4 cycles later S=0x0000, Cout=1, Ovf=0. Carry ripples across all group registers.
- A=0x7FFF, B=0x0001, Cin=0, Sub=0 -> S=0x8000, Cout=0, Ovf=1. Then A=0x1234, B=0x4321, Cin=1 on the next cycle -> S=0x5556, Cout=0, Ovf=0 exactly one cycle later.
- Sub=1: A=0x0005, B=0x0007, Cin=0 -> S=0xFFFE, Cout=0, Ovf=0. A=0x8000, B=0x0001, Cin=0 -> S=0x7FFF, Cout=1, Ovf=1. A=0x0010, B=0x0003, Cin=1 -> S=0x000C, Cout=1.
- Backpressure: stream 8 back-to-back ops, drop out_ready for 3 cycles after the first result -> in_ready=0 for exactly those cycles, S held stable, all 8 results in order, none lost or repeated.
- Bubbles: alternate in_valid 1/0 for 6 cycles -> results appear with the same 1/0 spacing, each 4 cycles after its accept.
- Reset: assert rst_n=0 for 1 cycle with 3 ops in flight -> out_valid=0, S=0, Cout=0, Ovf=0 next cycle, no stale results ever appear, and a new op accepted afterwards emerges with latency 4.
